// File: rtl/target_box_detect.sv
// Bounding-box detector for a binary frame-difference stream: accumulates the extent of
// foreground pixels per frame, latches it at frame end and overlays it on the next frame.
module target_box_detect #(
    parameter int IMG_HDISP  = 640,
    parameter int IMG_VDISP  = 480,
    parameter int MIN_PIXELS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_img_bit,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_img_bit,
    output logic       post_box_edge,
    output logic [9:0] box_x_min,
    output logic [9:0] box_x_max,
    output logic [9:0] box_y_min,
    output logic [9:0] box_y_max,
    output logic       target_found,
    output logic       box_valid
);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        IN_FRAME   = 2'd1,
        LATCH      = 2'd2
    } state_t;

    localparam logic [9:0]  X_LAST  = 10'(IMG_HDISP - 1);
    localparam logic [9:0]  Y_END   = 10'(IMG_VDISP);
    localparam logic [18:0] MIN_CNT = 19'(MIN_PIXELS);
    localparam logic [18:0] CNT_MAX = 19'h7FFFF;

    state_t      state_r, state_s;
    logic        vsync_d_r, href_d_r, armed_r;
    logic        line_over_r;
    logic [9:0]  x_r, y_r;
    logic [9:0]  x_min_r, x_max_r, y_min_r, y_max_r;
    logic [18:0] pix_cnt_r;

    logic vsync_rise_s, vsync_fall_s, href_fall_s, pix_qual_s;
    logic stat_en_s, latch_s, edge_hit_s;

    function automatic logic on_border(input logic [9:0] x, input logic [9:0] y,
                                       input logic [9:0] xl, input logic [9:0] xh,
                                       input logic [9:0] yl, input logic [9:0] yh);
        logic col_hit, row_hit;
        col_hit = ((x == xl) || (x == xh)) && (y >= yl) && (y <= yh);
        row_hit = ((y == yl) || (y == yh)) && (x >= xl) && (x <= xh);
        return col_hit || row_hit;
    endfunction

    // Edge detection and pixel qualification; armed_r blocks a frame already in progress at reset release.
    always_comb begin
        vsync_rise_s = per_frame_vsync & ~vsync_d_r & armed_r;
        vsync_fall_s = ~per_frame_vsync & vsync_d_r;
        href_fall_s  = ~per_frame_href & href_d_r;
        pix_qual_s   = per_frame_vsync & per_frame_href;
        stat_en_s    = (state_r == IN_FRAME) & pix_qual_s & ~line_over_r & (y_r < Y_END);
        latch_s      = (state_r == IN_FRAME) & vsync_fall_s;
        edge_hit_s   = target_found & stat_en_s &
                       on_border(x_r, y_r, box_x_min, box_x_max, box_y_min, box_y_max);
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            WAIT_FRAME: if (vsync_rise_s) state_s = IN_FRAME; else state_s = WAIT_FRAME;
            IN_FRAME:   if (vsync_fall_s) state_s = LATCH;    else state_s = IN_FRAME;
            LATCH:      state_s = WAIT_FRAME;
            default:    state_s = WAIT_FRAME;
        endcase
    end

    // State register and input edge-detect history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= WAIT_FRAME;
            vsync_d_r <= 1'b0;
            href_d_r  <= 1'b0;
            armed_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            vsync_d_r <= per_frame_vsync;
            href_d_r  <= per_frame_href;
            armed_r   <= armed_r | ~per_frame_vsync;
        end
    end

    // Pixel position counters and running foreground statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r         <= 10'd0;
            y_r         <= 10'd0;
            line_over_r <= 1'b0;
            x_min_r     <= 10'd0;
            x_max_r     <= 10'd0;
            y_min_r     <= 10'd0;
            y_max_r     <= 10'd0;
            pix_cnt_r   <= 19'd0;
        end else if ((state_r == WAIT_FRAME) && vsync_rise_s) begin
            x_r         <= 10'd0;
            y_r         <= 10'd0;
            line_over_r <= 1'b0;
            x_min_r     <= 10'd1023;
            x_max_r     <= 10'd0;
            y_min_r     <= 10'd1023;
            y_max_r     <= 10'd0;
            pix_cnt_r   <= 19'd0;
        end else if (state_r == IN_FRAME) begin
            if (href_fall_s) begin
                x_r         <= 10'd0;
                line_over_r <= 1'b0;
                if (y_r < Y_END) y_r <= y_r + 10'd1;
            end else if (pix_qual_s && !line_over_r) begin
                if (x_r == X_LAST) line_over_r <= 1'b1;
                else               x_r <= x_r + 10'd1;
            end
            if (stat_en_s && per_img_bit) begin
                if (x_r < x_min_r) x_min_r <= x_r;
                if (x_r > x_max_r) x_max_r <= x_r;
                if (y_r < y_min_r) y_min_r <= y_r;
                if (y_r > y_max_r) y_max_r <= y_r;
                if (pix_cnt_r != CNT_MAX) pix_cnt_r <= pix_cnt_r + 19'd1;
            end
        end
    end

    // One-cycle delayed video with the previous frame's box overlaid.
    always_ff @(posedge clk) begin
        if (rst) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_img_bit     <= 1'b0;
            post_box_edge    <= 1'b0;
        end else begin
            post_frame_vsync <= per_frame_vsync;
            post_frame_href  <= per_frame_href;
            post_img_bit     <= per_img_bit;
            post_box_edge    <= edge_hit_s;
        end
    end

    // Box latch on the transition into LATCH; held until the next completed frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            box_x_min    <= 10'd0;
            box_x_max    <= 10'd0;
            box_y_min    <= 10'd0;
            box_y_max    <= 10'd0;
            target_found <= 1'b0;
            box_valid    <= 1'b0;
        end else begin
            box_valid <= latch_s;
            if (latch_s) begin
                if (pix_cnt_r >= MIN_CNT) begin
                    box_x_min    <= x_min_r;
                    box_x_max    <= x_max_r;
                    box_y_min    <= y_min_r;
                    box_y_max    <= y_max_r;
                    target_found <= 1'b1;
                end else begin
                    box_x_min    <= 10'd0;
                    box_x_max    <= 10'd0;
                    box_y_min    <= 10'd0;
                    box_y_max    <= 10'd0;
                    target_found <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_target_box_detect.sv
// Bench for target_box_detect: two instances (MIN_PIXELS 64 and 1) share one stimulus stream;
// a frame-level model predicts every output each cycle, and directed frames carry fixed expectations.
module tb_target_box_detect;

    logic clk = 1'b0;
    logic rst, per_frame_vsync, per_frame_href, per_img_bit;

    logic       a_pv, a_ph, a_pb, a_pe, a_tf, a_bv;
    logic [9:0] a_x0, a_x1, a_y0, a_y1;
    logic       b_pv, b_ph, b_pb, b_pe, b_tf, b_bv;
    logic [9:0] b_x0, b_x1, b_y0, b_y1;

    always #5 clk = ~clk;

    target_box_detect #(.IMG_HDISP(640), .IMG_VDISP(480), .MIN_PIXELS(64)) dut_a (
        .clk(clk), .rst(rst), .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
        .per_img_bit(per_img_bit), .post_frame_vsync(a_pv), .post_frame_href(a_ph),
        .post_img_bit(a_pb), .post_box_edge(a_pe), .box_x_min(a_x0), .box_x_max(a_x1),
        .box_y_min(a_y0), .box_y_max(a_y1), .target_found(a_tf), .box_valid(a_bv));

    target_box_detect #(.IMG_HDISP(640), .IMG_VDISP(480), .MIN_PIXELS(1)) dut_b (
        .clk(clk), .rst(rst), .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
        .per_img_bit(per_img_bit), .post_frame_vsync(b_pv), .post_frame_href(b_ph),
        .post_img_bit(b_pb), .post_box_edge(b_pe), .box_x_min(b_x0), .box_x_max(b_x1),
        .box_y_min(b_y0), .box_y_max(b_y1), .target_found(b_tf), .box_valid(b_bv));

    typedef struct packed {
        int n_lines, line_len, short_len;
        int fx0, fx1, fy0, fy1;
        int cut, rst_line, no_gap;
        int ax0, ax1, ay0, ay1, atf;
        int bx0, bx1, by0, by1, btf;
        int e_bv, e_edges;
    } frame_t;

    int n_pass = 0, n_total = 0;
    int thr [2] = '{64, 1};
    int lbox [2][4];
    int ltf [2];
    int cnt, xmn, xmx, ymn, ymx, px, py;
    int frame_active = 0, prev_vs = 0, prev_hs = 0;
    int bv_cnt, edge_cnt;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act != exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else            n_pass++;
    endtask

    function automatic int on_box(int k, int x, int y);
        return (((x == lbox[k][0]) || (x == lbox[k][1])) && (y >= lbox[k][2]) && (y <= lbox[k][3])) ||
               (((y == lbox[k][2]) || (y == lbox[k][3])) && (x >= lbox[k][0]) && (x <= lbox[k][1]));
    endfunction

    // One clock of stimulus; predicts and checks every output of both instances.
    task automatic step(input int r, input int vs, input int hs, input int b);
        int q, inr, fall;
        int exp_pe [2];
        int act [2][10];
        string pf;
        q    = vs & hs;
        inr  = (px < 640) && (py < 480);
        fall = (r == 0) && frame_active && prev_vs && !vs;
        for (int k = 0; k < 2; k++)
            exp_pe[k] = ((r == 0) && frame_active && q && inr && ltf[k] && on_box(k, px, py)) ? 1 : 0;
        if (r != 0) begin
            for (int k = 0; k < 2; k++) begin
                ltf[k] = 0;
                for (int j = 0; j < 4; j++) lbox[k][j] = 0;
            end
            frame_active = 0;
        end else if (fall) begin
            for (int k = 0; k < 2; k++) begin
                ltf[k] = (cnt >= thr[k]) ? 1 : 0;
                lbox[k][0] = ltf[k] ? xmn : 0;
                lbox[k][1] = ltf[k] ? xmx : 0;
                lbox[k][2] = ltf[k] ? ymn : 0;
                lbox[k][3] = ltf[k] ? ymx : 0;
            end
        end
        rst = r[0]; per_frame_vsync = vs[0]; per_frame_href = hs[0]; per_img_bit = b[0];
        @(posedge clk);
        #1;
        act[0] = '{int'(a_pv), int'(a_ph), int'(a_pb), int'(a_pe), int'(a_bv),
                   int'(a_x0), int'(a_x1), int'(a_y0), int'(a_y1), int'(a_tf)};
        act[1] = '{int'(b_pv), int'(b_ph), int'(b_pb), int'(b_pe), int'(b_bv),
                   int'(b_x0), int'(b_x1), int'(b_y0), int'(b_y1), int'(b_tf)};
        for (int k = 0; k < 2; k++) begin
            pf = (k == 0) ? "a" : "b";
            chk({pf, "_post_vsync"}, act[k][0], (r != 0) ? 0 : vs);
            chk({pf, "_post_href"},  act[k][1], (r != 0) ? 0 : hs);
            chk({pf, "_post_bit"},   act[k][2], (r != 0) ? 0 : b);
            chk({pf, "_post_edge"},  act[k][3], exp_pe[k]);
            chk({pf, "_box_valid"},  act[k][4], fall ? 1 : 0);
            chk({pf, "_x_min"},      act[k][5], lbox[k][0]);
            chk({pf, "_x_max"},      act[k][6], lbox[k][1]);
            chk({pf, "_y_min"},      act[k][7], lbox[k][2]);
            chk({pf, "_y_max"},      act[k][8], lbox[k][3]);
            chk({pf, "_found"},      act[k][9], ltf[k]);
        end
        if (a_bv) bv_cnt++;
        if (a_pe) edge_cnt++;
        if ((r == 0) && frame_active && q) begin
            if (inr && b) begin
                cnt++;
                if (px < xmn) xmn = px;
                if (px > xmx) xmx = px;
                if (py < ymn) ymn = py;
                if (py > ymx) ymx = py;
            end
            px++;
        end
        if ((r == 0) && frame_active && prev_hs && !hs) begin
            px = 0;
            py++;
        end
        if (fall) frame_active = 0;
        prev_vs = vs;
        prev_hs = hs;
    endtask

    // Streams one frame: foreground rectangle plus optional noise, cut line, reset or no lead-in gap.
    task automatic run_frame(input frame_t f, input int noise);
        int len, b, last;
        repeat ((f.no_gap != 0) ? 0 : 3) step(0, 0, 0, 0);
        frame_active = (f.no_gap != 0) ? 0 : 1;
        cnt = 0; xmn = 1023; xmx = 0; ymn = 1023; ymx = 0; px = 0; py = 0;
        bv_cnt = 0; edge_cnt = 0;
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        for (int y = 0; y < f.n_lines; y++) begin
            last = (y == f.n_lines - 1) && (f.cut > 0);
            if (y == f.rst_line) step(1, 1, 0, 0);
            len = ((y >= f.fy0) && (y <= f.fy1)) ? f.line_len : f.short_len;
            if (last) len = f.cut;
            for (int x = 0; x < len; x++) begin
                b = ((x >= f.fx0) && (x <= f.fx1) && (y >= f.fy0) && (y <= f.fy1)) ? 1 : 0;
                if ((noise != 0) && ($urandom_range(0, 99) == 0)) b = 1;
                step(0, 1, 1, b);
            end
            if (!last) begin
                step(0, 1, 0, 0);
                step(0, 1, 0, 0);
            end
        end
        if (f.cut == 0) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
    endtask

    frame_t tab [10];
    frame_t rf;

    initial begin
        rst = 1'b1; per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_img_bit = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ltf[k] = 0;
            for (int j = 0; j < 4; j++) lbox[k][j] = 0;
        end
        cnt = 0; xmn = 1023; xmx = 0; ymn = 1023; ymx = 0; px = 0; py = 0;

        //            lines len  short  fx0 fx1 fy0 fy1  cut rstl gap  A box / found           B box / found           bv edges
        tab[0] = '{64,  130, 130,  100, 119, 50,  59,  0, -1, 0,  100, 119, 50, 59, 1,  100, 119, 50, 59, 1,  1, 0};
        tab[1] = '{64,  130, 130,  100, 119, 50,  59,  0, -1, 0,  100, 119, 50, 59, 1,  100, 119, 50, 59, 1,  1, 56};
        tab[2] = '{8,   30,  30,   10,  19,  5,   5,   0, -1, 0,  0, 0, 0, 0, 0,        10, 19, 5, 5, 1,        1, 0};
        tab[3] = '{480, 640, 1,    639, 639, 479, 479, 0, -1, 0,  0, 0, 0, 0, 0,        639, 639, 479, 479, 1,  1, 0};
        tab[4] = '{3,   700, 700,  630, 699, 1,   1,   0, -1, 0,  0, 0, 0, 0, 0,        630, 639, 1, 1, 1,      1, 0};
        tab[5] = '{4,   80,  80,   0,   79,  0,   3,  40, -1, 0,  0, 79, 0, 3, 1,        0, 79, 0, 3, 1,         1, 0};
        tab[6] = '{4,   80,  80,   10,  20,  1,   2,   0, -1, 1,  0, 79, 0, 3, 1,        0, 79, 0, 3, 1,         0, 0};
        tab[7] = '{12,  40,  40,   5,   9,   2,   4,   0, -1, 0,  0, 0, 0, 0, 0,        5, 9, 2, 4, 1,          1, 82};
        tab[8] = '{220, 4,   4,    0,   3,   100, 210, 0, 200, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0,          0, 0};
        tab[9] = '{64,  130, 130,  100, 119, 50,  59,  0, -1, 0,  100, 119, 50, 59, 1,  100, 119, 50, 59, 1,  1, 0};

        repeat (3) step(1, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            run_frame(tab[i], 0);
            chk($sformatf("t%0d_a_x_min", i), int'(a_x0), tab[i].ax0);
            chk($sformatf("t%0d_a_x_max", i), int'(a_x1), tab[i].ax1);
            chk($sformatf("t%0d_a_y_min", i), int'(a_y0), tab[i].ay0);
            chk($sformatf("t%0d_a_y_max", i), int'(a_y1), tab[i].ay1);
            chk($sformatf("t%0d_a_found", i), int'(a_tf), tab[i].atf);
            chk($sformatf("t%0d_b_x_min", i), int'(b_x0), tab[i].bx0);
            chk($sformatf("t%0d_b_x_max", i), int'(b_x1), tab[i].bx1);
            chk($sformatf("t%0d_b_y_min", i), int'(b_y0), tab[i].by0);
            chk($sformatf("t%0d_b_y_max", i), int'(b_y1), tab[i].by1);
            chk($sformatf("t%0d_b_found", i), int'(b_tf), tab[i].btf);
            chk($sformatf("t%0d_valid_pulses", i), bv_cnt, tab[i].e_bv);
            chk($sformatf("t%0d_edge_pixels", i), edge_cnt, tab[i].e_edges);
        end

        for (int i = 0; i < 8; i++) begin
            rf = '{default: 0};
            rf.rst_line = -1;
            if (i % 4 == 3) begin
                rf.n_lines  = $urandom_range(1, 6);
                rf.line_len = $urandom_range(600, 720);
            end else begin
                rf.n_lines  = $urandom_range(1, 20);
                rf.line_len = $urandom_range(1, 150);
            end
            rf.short_len = $urandom_range(1, rf.line_len);
            rf.fx0 = $urandom_range(0, rf.line_len - 1);
            rf.fx1 = rf.fx0 + $urandom_range(0, 30);
            rf.fy0 = $urandom_range(0, rf.n_lines - 1);
            rf.fy1 = rf.fy0 + $urandom_range(0, 5);
            run_frame(rf, 1);
        end

        repeat (4) step(0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
